// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state type and decode helpers for the load/store unit
package lsu_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_STORE_RD = 3'd2,
      ST_STORE_WR = 3'd3,
      ST_RESP     = 3'd4
   } lsu_state_t;

   // Stores only come in B/H/W; loads add the unsigned B/H variants.
   function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
      logic bad;
      if (is_store) bad = !(f3 inside {F3_B, F3_H, F3_W});
      else          bad = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      return bad;
   endfunction

   // funct3[1:0] encodes the access size for every legal funct3.
   function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      case (f3[1:0])
         2'b01:   bad = off[0];
         2'b10:   bad = (off != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, response and data-memory signals of the load/store unit
interface load_store_unit_if
   import lsu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
);
   logic            i_lsu_req_valid;
   logic            o_lsu_req_ready;
   logic            i_lsu_is_store;
   logic [2:0]      i_lsu_funct3;
   logic [XLEN-1:0] i_lsu_addr;
   logic [XLEN-1:0] i_lsu_wdata;
   logic            o_lsu_rsp_valid;
   logic [XLEN-1:0] o_lsu_rdata;
   logic            o_lsu_misaligned;
   logic [XLEN-1:0] o_lsu_mem_A;
   logic [XLEN-1:0] o_lsu_mem_WD;
   logic            o_lsu_mem_WE;
   logic [XLEN-1:0] i_lsu_mem_RD;

   // Environment view: core request side plus the data memory.
   modport master (
      output i_lsu_req_valid, i_lsu_is_store, i_lsu_funct3, i_lsu_addr, i_lsu_wdata,
      output i_lsu_mem_RD,
      input  o_lsu_req_ready, o_lsu_rsp_valid, o_lsu_rdata, o_lsu_misaligned,
      input  o_lsu_mem_A, o_lsu_mem_WD, o_lsu_mem_WE
   );

   // LSU view.
   modport slave (
      input  i_lsu_req_valid, i_lsu_is_store, i_lsu_funct3, i_lsu_addr, i_lsu_wdata,
      input  i_lsu_mem_RD,
      output o_lsu_req_ready, o_lsu_rsp_valid, o_lsu_rdata, o_lsu_misaligned,
      output o_lsu_mem_A, o_lsu_mem_WD, o_lsu_mem_WE
   );
endinterface

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - lane extraction with extension for loads, lane merge for sub-word stores
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] rd,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic        sext;

   // funct3[2] set means the unsigned variant; word accesses pass through.
   always_comb begin
      byte_v     = rd[{off, 3'b000} +: 8];
      half_v     = rd[{off[1], 4'b0000} +: 16];
      sext       = ~funct3[2];
      load_data  = rd;
      store_word = rd;
      case (funct3)
         F3_B, F3_BU: begin
            load_data = {{24{sext & byte_v[7]}}, byte_v};
            store_word[{off, 3'b000} +: 8] = wdata[7:0];
         end
         F3_H, F3_HU: begin
            load_data = {{16{sext & half_v[15]}}, half_v};
            store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
         end
         default: begin
            load_data  = rd;
            store_word = wdata;
         end
      endcase
   end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store initiator for a word-only data memory
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN        = XLEN_DEFAULT,
   parameter bit ALIGN_CHECK = 1'b1
)(
   input  logic              i_lsu_clk,
   input  logic              i_lsu_rst_n,
   load_store_unit_if.slave  bus
);
   lsu_state_t      state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [XLEN-1:0] wd_q, wd_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            mis_q, mis_d;
   logic            req_err;
   logic [31:0]     lane_load;
   logic [31:0]     lane_store;

   lsu_byte_lane u_lane (
      .funct3     (funct3_q),
      .off        (addr_q[1:0]),
      .rd         (bus.i_lsu_mem_RD),
      .wdata      (wdata_q),
      .load_data  (lane_load),
      .store_word (lane_store)
   );

   // Handshake, write enable and response are decoded straight from the state so reset clears them at once.
   assign bus.o_lsu_req_ready  = (state_q == ST_IDLE);
   assign bus.o_lsu_mem_WE     = (state_q == ST_STORE_WR);
   assign bus.o_lsu_rsp_valid  = (state_q == ST_RESP);
   assign bus.o_lsu_mem_A      = {addr_q[XLEN-1:2], 2'b00};
   assign bus.o_lsu_mem_WD     = wd_q;
   assign bus.o_lsu_rdata      = rdata_q;
   assign bus.o_lsu_misaligned = mis_q;

   assign req_err = f3_illegal(bus.i_lsu_is_store, bus.i_lsu_funct3) |
                    (ALIGN_CHECK & addr_misaligned(bus.i_lsu_funct3, bus.i_lsu_addr[1:0]));

   // Next-state and next-output decode for the access sequencer.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      funct3_d = funct3_q;
      wd_d     = wd_q;
      rdata_d  = rdata_q;
      mis_d    = mis_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_lsu_req_valid) begin
               addr_d   = bus.i_lsu_addr;
               wdata_d  = bus.i_lsu_wdata;
               funct3_d = bus.i_lsu_funct3;
               wd_d     = bus.i_lsu_wdata;
               rdata_d  = '0;
               mis_d    = req_err;
               if (req_err)                         state_d = ST_RESP;
               else if (!bus.i_lsu_is_store)        state_d = ST_LOAD;
               else if (bus.i_lsu_funct3 == F3_W)   state_d = ST_STORE_WR;
               else                                 state_d = ST_STORE_RD;
            end
         end
         ST_LOAD: begin
            rdata_d = lane_load;
            state_d = ST_RESP;
         end
         ST_STORE_RD: begin
            wd_d    = lane_store;
            state_d = ST_STORE_WR;
         end
         ST_STORE_WR: state_d = ST_RESP;
         ST_RESP:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // State and all latched request/response registers.
   always_ff @(posedge i_lsu_clk or negedge i_lsu_rst_n) begin
      if (!i_lsu_rst_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         wd_q     <= '0;
         rdata_q  <= '0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         wd_q     <= wd_d;
         rdata_q  <= rdata_d;
         mis_q    <= mis_d;
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a byte-addressed model
module tb_load_store_unit;
   localparam bit ALIGN = 1'b1;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [31:0] mem [0:15];
   logic [7:0]  ref_mem [0:63];

   load_store_unit_if bus ();

   load_store_unit #(.XLEN(32), .ALIGN_CHECK(ALIGN)) dut (
      .i_lsu_clk   (clk),
      .i_lsu_rst_n (rst_n),
      .bus         (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.i_lsu_mem_RD = mem[bus.o_lsu_mem_A[5:2]];

   always @(posedge clk) begin
      if (bus.o_lsu_mem_WE) mem[bus.o_lsu_mem_A[5:2]] <= bus.o_lsu_mem_WD;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input int idx);
      return {ref_mem[idx*4+3], ref_mem[idx*4+2], ref_mem[idx*4+1], ref_mem[idx*4]};
   endfunction

   task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] got);
      bit          legal;
      bit          err;
      int          size;
      int          base;
      int          lat;
      int          we_n;
      int          exp_lat;
      logic [31:0] exp_rdata;
      logic [31:0] exp_word;
      logic [31:0] we_a;
      logic [31:0] we_d;

      legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      err   = !legal || (ALIGN && (a % size) != 0);
      base  = int'(a[5:0]) / size * size;
      exp_rdata = 32'h0;
      exp_word  = 32'h0;
      if (err) begin
         exp_lat = 1;
      end else if (!st) begin
         exp_lat = 2;
         for (int i = 0; i < size; i++) exp_rdata = exp_rdata | (32'(ref_mem[base+i]) << (8*i));
         if (!f3[2] && size < 4 && exp_rdata[8*size-1]) exp_rdata = exp_rdata | (32'hFFFFFFFF << (8*size));
      end else begin
         exp_lat = (size == 4) ? 2 : 3;
         for (int i = 0; i < size; i++) ref_mem[base+i] = wd[8*i +: 8];
         exp_word = ref_word(base / 4);
      end

      @(negedge clk);
      chk("req_ready", {31'b0, bus.o_lsu_req_ready}, 32'd1);
      bus.i_lsu_req_valid = 1'b1;
      bus.i_lsu_is_store  = st;
      bus.i_lsu_funct3    = f3;
      bus.i_lsu_addr      = a;
      bus.i_lsu_wdata     = wd;
      @(posedge clk);
      lat  = 0;
      we_n = 0;
      we_a = 32'h0;
      we_d = 32'h0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) bus.i_lsu_req_valid = 1'b0;
         if (bus.o_lsu_mem_WE) begin
            we_n++;
            we_a = bus.o_lsu_mem_A;
            we_d = bus.o_lsu_mem_WD;
         end
      end while (!bus.o_lsu_rsp_valid && lat < 8);

      chk("latency", lat, exp_lat);
      chk("rdata", bus.o_lsu_rdata, exp_rdata);
      chk("misaligned", {31'b0, bus.o_lsu_misaligned}, {31'b0, err});
      chk("we_count", we_n, (st && !err) ? 1 : 0);
      if (st && !err) begin
         chk("we_addr", we_a, a & 32'hFFFFFFFC);
         chk("we_data", we_d, exp_word);
      end
      if (!err) chk("mem_A", bus.o_lsu_mem_A, a & 32'hFFFFFFFC);
      got = bus.o_lsu_rdata;
   endtask

   initial begin
      logic [31:0] r;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.i_lsu_req_valid = 1'b0;
      bus.i_lsu_is_store  = 1'b0;
      bus.i_lsu_funct3    = 3'b0;
      bus.i_lsu_addr      = 32'h0;
      bus.i_lsu_wdata     = 32'h0;
      for (int w = 0; w < 16; w++) begin
         mem[w] = (w == 4) ? 32'h8899AABB : $urandom;
         for (int b = 0; b < 4; b++) ref_mem[w*4+b] = mem[w][8*b +: 8];
      end

      repeat (2) @(negedge clk);
      chk("rst_ready", {31'b0, bus.o_lsu_req_ready}, 32'd1);
      chk("rst_rsp", {31'b0, bus.o_lsu_rsp_valid}, 32'd0);
      chk("rst_we", {31'b0, bus.o_lsu_mem_WE}, 32'd0);
      chk("rst_A", bus.o_lsu_mem_A, 32'h0);
      chk("rst_WD", bus.o_lsu_mem_WD, 32'h0);
      chk("rst_rdata", bus.o_lsu_rdata, 32'h0);
      chk("rst_mis", {31'b0, bus.o_lsu_misaligned}, 32'd0);
      rst_n = 1'b1;

      do_req(0, 3'b010, 32'h10, 32'h0, r);        chk("lw_10", r, 32'h8899AABB);
      do_req(0, 3'b000, 32'h13, 32'h0, r);        chk("lb_13", r, 32'hFFFFFF88);
      do_req(0, 3'b100, 32'h13, 32'h0, r);        chk("lbu_13", r, 32'h00000088);
      do_req(0, 3'b001, 32'h12, 32'h0, r);        chk("lh_12", r, 32'hFFFF8899);
      do_req(0, 3'b101, 32'h10, 32'h0, r);        chk("lhu_10", r, 32'h0000AABB);
      do_req(1, 3'b000, 32'h11, 32'h12345677, r);
      do_req(0, 3'b010, 32'h10, 32'h0, r);        chk("sb_readback", r, 32'h889977BB);
      do_req(1, 3'b010, 32'h14, 32'hDEADBEEF, r);
      do_req(1, 3'b001, 32'h16, 32'h0000CAFE, r);
      do_req(0, 3'b010, 32'h14, 32'h0, r);        chk("sh_readback", r, 32'hCAFEBEEF);
      do_req(0, 3'b001, 32'h11, 32'h0, r);
      do_req(1, 3'b010, 32'h16, 32'h11111111, r);
      do_req(0, 3'b011, 32'h10, 32'h0, r);
      do_req(1, 3'b100, 32'h10, 32'h0, r);

      for (int n = 0; n < 300; n++) begin
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                $urandom & 32'h0000_0F3F, $urandom, r);
      end

      // Reset during the read half of a sub-word store must suppress the write.
      @(negedge clk);
      bus.i_lsu_req_valid = 1'b1;
      bus.i_lsu_is_store  = 1'b1;
      bus.i_lsu_funct3    = 3'b000;
      bus.i_lsu_addr      = 32'h21;
      bus.i_lsu_wdata     = 32'h000000A5;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      bus.i_lsu_req_valid = 1'b0;
      #1;
      chk("abort_we_now", {31'b0, bus.o_lsu_mem_WE}, 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("abort_we", {31'b0, bus.o_lsu_mem_WE}, 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready", {31'b0, bus.o_lsu_req_ready}, 32'd1);
      chk("abort_rsp", {31'b0, bus.o_lsu_rsp_valid}, 32'd0);
      chk("abort_we_after", {31'b0, bus.o_lsu_mem_WE}, 32'd0);
      chk("abort_A", bus.o_lsu_mem_A, 32'h0);
      chk("abort_WD", bus.o_lsu_mem_WD, 32'h0);
      chk("abort_rdata", bus.o_lsu_rdata, 32'h0);
      chk("abort_mis", {31'b0, bus.o_lsu_misaligned}, 32'd0);
      chk("abort_mem", mem[8], ref_word(8));

      for (int w = 0; w < 16; w++) chk("final_mem", mem[w], ref_word(w));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
